crc8_serial_checker: RTL

- Receive-side counterpart of the serial CRC-8 generator.
- Runs the same LFSR over a serial message qualified by ACTIVE, then compares the 8 trailing CRC bits (CRC_IN/CRC_VLD, LSB first) against its own remainder.
- Reports pass/fail, mismatch count and protocol errors.
- Sits in the link receive path, directly fed by the generator's CRC/Valid outputs.

---
 rtl/crc8_serial_checker.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/crc8_serial_checker.sv
// ----------------------------------------------------------------------------
// crc8_serial_checker
//   Receive-side CRC-8 checker for a serial link.  Runs the same LFSR as the
//   serial CRC-8 generator over the message bits qualified by ACTIVE.  It then
//   compares the 8 trailing CRC bits (CRC_IN/CRC_VLD, LSB first) against its
//   own remainder and reports the result.
//
// Parameters
//   SEED    LFSR value at reset, after any abort, and after DONE if RESEED=1
//   TAPS    feedback tap mask; bit i (i<7) XORs feedback into LFSR[i]
//   TIMEOUT idle cycles tolerated in WAIT before the first CRC_VLD (1..15)
//   RESEED  0: keep post-check LFSR state (chains like the generator)
//           1: reload SEED at every frame end
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   asynchronous active-high reset
//   DATA      in   serial message bit, valid while ACTIVE=1
//   ACTIVE    in   message-phase qualifier
//   CRC_IN    in   received CRC bit, LSB first
//   CRC_VLD   in   qualifier for CRC_IN
//   DONE      out  one-cycle pulse, check complete
//   CRC_OK    out  all 8 CRC bits matched (valid from DONE to next frame)
//   CRC_ERR   out  at least one CRC bit mismatched (same validity)
//   ERR_CNT   out  number of mismatching CRC bits, 0..8 (same validity)
//   PROTO_ERR out  one-cycle pulse, frame aborted
// ----------------------------------------------------------------------------
module crc8_serial_checker #(
  parameter logic [7:0]  SEED    = 8'hD8,
  parameter logic [7:0]  TAPS    = 8'h44,
  parameter int unsigned TIMEOUT = 4,
  parameter bit          RESEED  = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA,
  input  logic       ACTIVE,
  input  logic       CRC_IN,
  input  logic       CRC_VLD,
  output logic       DONE,
  output logic       CRC_OK,
  output logic       CRC_ERR,
  output logic [3:0] ERR_CNT,
  output logic       PROTO_ERR
);

  localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic       mism_q, mism_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic       proto_q, proto_d;

  // One message-bit step of the LFSR.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic d);
    logic       fb;
    logic [7:0] n;
    fb   = l[0] ^ d;
    n    = '0;
    n[7] = fb;
    for (int unsigned i = 0; i < 7; i++) begin
      n[i] = l[i+1] ^ (TAPS[i] & fb);
    end
    return n;
  endfunction

  logic       bit_mis;
  logic       mism_new;
  logic [3:0] cnt_inc;
  logic [7:0] lfsr_shr;

  always_comb begin
    bit_mis  = CRC_IN ^ lfsr_q[0];
    mism_new = mism_q | bit_mis;
    cnt_inc  = cnt_q + {3'b000, bit_mis};
    lfsr_shr = {1'b0, lfsr_q[7:1]};
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    mism_d  = mism_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    err_d   = err_q;
    done_d  = 1'b0;
    proto_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ACTIVE) begin
          lfsr_d  = lfsr_step(lfsr_q, DATA);
          ok_d    = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          mism_d  = 1'b0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (ACTIVE) begin
          lfsr_d = lfsr_step(lfsr_q, DATA);
        end else begin
          gap_d   = 4'd1;
          state_d = S_WAIT;
        end
      end

      S_WAIT, S_CHECK: begin
        if (ACTIVE) begin
          // A new frame overrides the pending check; it starts from SEED
          // and this cycle's DATA bit already belongs to it.
          proto_d = 1'b1;
          lfsr_d  = lfsr_step(SEED, DATA);
          ok_d    = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          mism_d  = 1'b0;
          idx_d   = '0;
          state_d = S_DATA;
        end else if (CRC_VLD) begin
          cnt_d  = cnt_inc;
          mism_d = mism_new;
          lfsr_d = lfsr_shr;
          if (state_q == S_WAIT) begin
            idx_d   = 3'd1;
            state_d = S_CHECK;
          end else if (idx_q == 3'd7) begin
            done_d  = 1'b1;
            ok_d    = ~mism_new;
            err_d   = mism_new;
            idx_d   = '0;
            lfsr_d  = RESEED ? SEED : lfsr_shr;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (state_q == S_CHECK || gap_q >= TIMEOUT_L) begin
          // Gap inside the CRC field, or no CRC within TIMEOUT cycles.
          proto_d = 1'b1;
          lfsr_d  = SEED;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      gap_q   <= '0;
      mism_q  <= 1'b0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      mism_q  <= mism_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      done_q  <= done_d;
      proto_q <= proto_d;
    end
  end

  assign DONE      = done_q;
  assign CRC_OK    = ok_q;
  assign CRC_ERR   = err_q;
  assign ERR_CNT   = cnt_q;
  assign PROTO_ERR = proto_q;

endmodule
